// File: rtl/dispatch_queue.sv
// dispatch_queue: circular instruction queue between fetch and dispatch.
// Accepts up to four instructions per cycle, compacted in program order with
// no holes, and presents the two oldest entries to the consumer, which takes
// every valid output slot when out_ready is high.
module dispatch_queue #(
  parameter int IW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IW-1:0]            ins1,
  input  logic [IW-1:0]            ins2,
  input  logic [IW-1:0]            ins3,
  input  logic [IW-1:0]            ins4,
  input  logic                     ins1_vld,
  input  logic                     ins2_vld,
  input  logic                     ins3_vld,
  input  logic                     ins4_vld,
  input  logic                     flush,
  output logic                     in_ready,
  output logic [IW-1:0]            out_ins1,
  output logic [IW-1:0]            out_ins2,
  output logic                     out_vld1,
  output logic                     out_vld2,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [IW-1:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [IW-1:0] slot_ins [4];
  logic [3:0]    slot_vld;
  logic [3:0]    wr_en;
  logic [AW-1:0] wr_addr [4];
  logic [2:0]    push_cnt;
  logic [2:0]    pop_cnt;
  logic          accept;
  logic [AW-1:0] head_p1;

  assign slot_ins[0] = ins1;
  assign slot_ins[1] = ins2;
  assign slot_ins[2] = ins3;
  assign slot_ins[3] = ins4;
  assign slot_vld    = {ins4_vld, ins3_vld, ins2_vld, ins1_vld};

  // Ready depends only on registered occupancy: room for a full group of four.
  assign in_ready = (count_q <= CW'(DEPTH - 4));
  assign accept   = in_ready & ~flush & ~rst;

  // Compact valid slots: each valid slot goes to tail plus the number of
  // valid slots ahead of it in program order.
  // NOTE: push_cnt is a running sum read after each update inside this loop,
  // so blocking assignments are required here; it also gets a default first
  // so no latch is inferred.
  always_comb begin
    push_cnt = '0;
    wr_en    = '0;
    for (int k = 0; k < 4; k++) begin
      wr_addr[k] = tail_q + AW'(push_cnt);
      wr_en[k]   = accept & slot_vld[k];
      push_cnt   = push_cnt + {2'b00, wr_en[k]};
    end
  end

  // Consumer takes every valid output slot when out_ready is high.
  always_comb begin
    pop_cnt = out_ready ? ({2'b00, out_vld1} + {2'b00, out_vld2}) : 3'd0;
    head_d  = head_q + AW'(pop_cnt);
    tail_d  = tail_q + AW'(push_cnt);
    count_d = count_q + CW'(push_cnt) - CW'(pop_cnt);
  end

  // Pointer and occupancy registers; reset beats flush, flush beats push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage writes; up to four distinct entries per cycle.
  // NOTE: storage is deliberately left out of reset -- the pointers and count
  // define which entries are live, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_en[k]) mem_q[wr_addr[k]] <= slot_ins[k];
    end
  end

  assign head_p1  = head_q + AW'(1);
  assign count    = count_q;
  assign out_vld1 = (count_q >= CW'(1));
  assign out_vld2 = (count_q >= CW'(2));
  assign out_ins1 = out_vld1 ? mem_q[head_q]  : '0;
  assign out_ins2 = out_vld2 ? mem_q[head_p1] : '0;

endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: directed and randomized stimulus for dispatch_queue,
// checked each cycle against a queue-based reference model.
module tb_dispatch_queue;

  localparam int IW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] ins_a [4];
  logic [3:0]    vld_a;
  logic          flush;
  logic          out_ready;
  logic          in_ready;
  logic [IW-1:0] out_ins1, out_ins2;
  logic          out_vld1, out_vld2;
  logic [3:0]    count;

  int tests = 0;
  int fails = 0;

  // Reference model: the live entries, oldest first.
  logic [IW-1:0] mq [$];

  always #5 clk = ~clk;

  dispatch_queue #(.IW(IW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .ins1      (ins_a[0]),
    .ins2      (ins_a[1]),
    .ins3      (ins_a[2]),
    .ins4      (ins_a[3]),
    .ins1_vld  (vld_a[0]),
    .ins2_vld  (vld_a[1]),
    .ins3_vld  (vld_a[2]),
    .ins4_vld  (vld_a[3]),
    .flush     (flush),
    .in_ready  (in_ready),
    .out_ins1  (out_ins1),
    .out_ins2  (out_ins2),
    .out_vld1  (out_vld1),
    .out_vld2  (out_vld2),
    .out_ready (out_ready),
    .count     (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [IW-1:0] w1, input logic [IW-1:0] w2,
                        input logic [IW-1:0] w3, input logic [IW-1:0] w4,
                        input logic [3:0] v, input logic ordy,
                        input logic fl, input logic r);
    ins_a[0]  = w1;
    ins_a[1]  = w2;
    ins_a[2]  = w3;
    ins_a[3]  = w4;
    vld_a     = v;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
  endtask

  // Compare DUT outputs with the model at the falling edge, then advance the
  // model by the rules for the inputs currently applied, then clock.
  task automatic step();
    int sz;
    int npop;
    bit room;
    @(negedge clk);
    sz = mq.size();
    check("count",    32'(count),    32'(sz));
    check("in_ready", 32'(in_ready), 32'(DEPTH - sz >= 4));
    check("out_vld1", 32'(out_vld1), 32'(sz >= 1));
    check("out_vld2", 32'(out_vld2), 32'(sz >= 2));
    check("out_ins1", 32'(out_ins1), (sz >= 1) ? 32'(mq[0]) : 32'd0);
    check("out_ins2", 32'(out_ins2), (sz >= 2) ? 32'(mq[1]) : 32'd0);
    if (rst || flush) begin
      mq.delete();
    end else begin
      room = (DEPTH - sz >= 4);
      npop = out_ready ? ((sz >= 2) ? 2 : sz) : 0;
      repeat (npop) void'(mq.pop_front());
      if (room) begin
        for (int k = 0; k < 4; k++) if (vld_a[k]) mq.push_back(ins_a[k]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in('0, '0, '0, '0, 4'b0000, 1'b0, 1'b0, 1'b1);
    step();
    set_in('0, '0, '0, '0, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    set_in('0, '0, '0, '0, 4'b0000, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    mq.delete();
    // Reset held: outputs idle, ready high.
    step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count",    32'(count),    32'd0);
    set_in('0, '0, '0, '0, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Partial group compacts: slots 1,2,4 valid.
    set_in(16'h1001, 16'h2002, 16'h3003, 16'h4004, 4'b1011, 1'b0, 1'b0, 1'b0);
    step();
    check("grp_count", 32'(count),    32'd3);
    check("grp_ins1",  32'(out_ins1), 32'h1001);
    check("grp_ins2",  32'(out_ins2), 32'h2002);
    check("grp_vld",   32'({out_vld1, out_vld2}), 32'b11);

    // Fill to DEPTH, then an extra group is ignored.
    do_reset();
    set_in(16'hA000, 16'hA001, 16'hA002, 16'hA003, 4'b1111, 1'b0, 1'b0, 1'b0);
    step();
    set_in(16'hB000, 16'hB001, 16'hB002, 16'hB003, 4'b1111, 1'b0, 1'b0, 1'b0);
    step();
    check("full_count", 32'(count),    32'd8);
    check("full_ready", 32'(in_ready), 32'd0);
    set_in(16'hC000, 16'hC001, 16'hC002, 16'hC003, 4'b1111, 1'b0, 1'b0, 1'b0);
    step();
    check("full_hold", 32'(count), 32'd8);

    // Occupancy 5: ready is low, so the group is dropped while two pop.
    do_reset();
    set_in(16'h0101, 16'h0202, 16'h0303, 16'h0404, 4'b1111, 1'b0, 1'b0, 1'b0);
    step();
    set_in(16'h0505, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 1'b0, 1'b0, 1'b0);
    step();
    set_in(16'h0606, 16'h0707, 16'h0808, 16'h0909, 4'b1111, 1'b1, 1'b0, 1'b0);
    step();
    check("c5_count", 32'(count),    32'd3);
    check("c5_third", 32'(out_ins1), 32'h0303);

    // Wrap: bring head=tail=6, then push four across the end of the array.
    do_reset();
    set_in(16'h1111, 16'h1112, 16'h1113, 16'h1114, 4'b1111, 1'b0, 1'b0, 1'b0);
    step();
    set_in(16'h1115, 16'h1116, 16'h0000, 16'h0000, 4'b0011, 1'b0, 1'b0, 1'b0);
    step();
    set_in('0, '0, '0, '0, 4'b0000, 1'b1, 1'b0, 1'b0);
    step();
    step();
    step();
    check("wrap_empty", 32'(count), 32'd0);
    set_in(16'hE006, 16'hE007, 16'hE000, 16'hE001, 4'b1111, 1'b0, 1'b0, 1'b0);
    step();
    check("wrap_ins1", 32'(out_ins1), 32'hE006);
    check("wrap_ins2", 32'(out_ins2), 32'hE007);
    set_in('0, '0, '0, '0, 4'b0000, 1'b1, 1'b0, 1'b0);
    step();
    check("wrap_ins3", 32'(out_ins1), 32'hE000);
    check("wrap_ins4", 32'(out_ins2), 32'hE001);
    step();
    check("wrap_drain", 32'(count), 32'd0);

    // Single entry: only one pop.
    set_in(16'h5A5A, 16'h0000, 16'h0000, 16'h0000, 4'b0001, 1'b0, 1'b0, 1'b0);
    step();
    check("one_vld2", 32'(out_vld2), 32'd0);
    set_in('0, '0, '0, '0, 4'b0000, 1'b1, 1'b0, 1'b0);
    step();
    check("one_count", 32'(count),    32'd0);
    check("one_vld1",  32'(out_vld1), 32'd0);

    // Flush with a concurrent full group, then the same with reset as well.
    for (int r = 0; r < 2; r++) begin
      set_in(16'h7000, 16'h7001, 16'h7002, 16'h7003, 4'b1111, 1'b0, 1'b0, 1'b0);
      step();
      set_in(16'h7004, 16'h7005, 16'h0000, 16'h0000, 4'b0011, 1'b0, 1'b0, 1'b0);
      step();
      check("fl_pre", 32'(count), 32'd6);
      set_in(16'h7100, 16'h7101, 16'h7102, 16'h7103, 4'b1111, 1'b1, 1'b1, 1'(r));
      step();
      check("fl_count", 32'(count),    32'd0);
      check("fl_ready", 32'(in_ready), 32'd1);
      check("fl_vld",   32'({out_vld1, out_vld2}), 32'b00);
      set_in('0, '0, '0, '0, 4'b0000, 1'b0, 1'b0, 1'b0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 800; n++) begin
      set_in(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             4'($urandom), 1'($urandom_range(0, 2) != 0),
             1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 63) == 0));
      step();
    end
    set_in('0, '0, '0, '0, 4'b0000, 1'b0, 1'b0, 1'b0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
